clk_ratio_meter: RTL and testbench

- Measures the clock divider's output from the receiving side.
- Samples a divided clock in the `clk_ref` domain and counts reference cycles per period and per high phase.
- Reports the recovered division ratio, duty split and odd flag, plus a stability flag and a timeout for stopped or bypassed clocks.
- Sits beside the divider for self-check and ratio readback.

---
 rtl/clk_ratio_meter.sv | 99 +++++++++
 tb/tb_clk_ratio_meter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_ratio_meter.sv
// Recovers period, high/low split, odd flag and stability of a divided clock sampled in clk_ref.
// Results update two clk_ref edges after s1 first captures a rising level.
module clk_ratio_meter #(
  parameter int width = 8
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             i_div_clk,
  input  logic             i_meas_en,
  output logic [width-1:0] o_period,
  output logic [width-1:0] o_high,
  output logic [width-1:0] o_low,
  output logic             o_odd,
  output logic             o_valid,
  output logic             o_timeout
);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, FIRST, MEAS} state_t;

  localparam logic [width:0] CNT_MAX = {1'b1, {width{1'b0}}};
  localparam logic [width:0] CNT_ONE = {{width{1'b0}}, 1'b1};

  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [width:0]   cnt_q;
  logic [width:0]   cnt_inc;
  logic [width-1:0] high_tmp_q;
  logic             rise, fall, cnt_full;

  assign rise     = s2_q & ~s3_q;
  assign fall     = ~s2_q & s3_q;
  assign cnt_full = (cnt_q == CNT_MAX);
  assign cnt_inc  = cnt_full ? cnt_q : cnt_q + CNT_ONE;
  assign o_odd    = o_period[0];

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= i_div_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      high_tmp_q <= '0;
      o_period   <= '0;
      o_high     <= '0;
      o_low      <= '0;
      o_valid    <= 1'b0;
      o_timeout  <= 1'b0;
    end else if (!i_meas_en) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= WAIT_RISE;
          cnt_q   <= '0;
        end
        WAIT_RISE: begin
          cnt_q <= rise ? CNT_ONE : cnt_inc;
          if (rise) begin
            state_q   <= FIRST;
            o_timeout <= 1'b0;
          end
        end
        FIRST, MEAS: begin
          cnt_q <= rise ? CNT_ONE : cnt_inc;
          // A saturated count is over-range even if a rise lands on it, so 2^width periods time out.
          if (cnt_full) begin
            o_timeout <= 1'b1;
            o_valid   <= 1'b0;
            state_q   <= WAIT_RISE;
          end else if (rise) begin
            o_valid  <= (state_q == MEAS) && (cnt_q[width-1:0] == o_period) &&
                        (high_tmp_q == o_high);
            o_period <= cnt_q[width-1:0];
            o_high   <= high_tmp_q;
            o_low    <= cnt_q[width-1:0] - high_tmp_q;
            state_q  <= MEAS;
          end else if (fall) begin
            high_tmp_q <= cnt_q[width-1:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Drives directed and random divided clocks into clk_ratio_meter and checks every cycle against an edge-time model.
module tb_clk_ratio_meter;
  localparam int W = 8;
  localparam int LIM = 1 << W;

  logic         clk_ref = 1'b0;
  logic         rst = 1'b1;
  logic         i_div_clk = 1'b0;
  logic         i_meas_en = 1'b0;
  logic [W-1:0] o_period, o_high, o_low;
  logic         o_odd, o_valid, o_timeout;

  int total = 0;
  int bad = 0;
  int tcyc = 0;

  clk_ratio_meter #(.width(W)) dut (
    .clk_ref(clk_ref), .rst(rst), .i_div_clk(i_div_clk), .i_meas_en(i_meas_en),
    .o_period(o_period), .o_high(o_high), .o_low(o_low),
    .o_odd(o_odd), .o_valid(o_valid), .o_timeout(o_timeout)
  );

  always #5 clk_ref = ~clk_ref;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
    end
  endtask

  // Model: measurements are differences of edge indices at which rise/fall events are seen.
  int           ecnt, rise_at, fall_at, mode;   // mode: 0 off, 1 waiting, 2 first, 3 measuring
  logic [2:0]   m_pipe;
  logic [W-1:0] ep, eh, el;
  logic         ev, et;

  always @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      ecnt = 0; rise_at = 0; fall_at = 0; mode = 0; m_pipe = '0;
      ep = '0; eh = '0; el = '0; ev = 1'b0; et = 1'b0;
    end else begin
      automatic logic r = m_pipe[1] & ~m_pipe[2];
      automatic logic f = ~m_pipe[1] & m_pipe[2];
      automatic int   elapsed;
      ecnt++;
      tcyc++;
      elapsed = ecnt - rise_at;
      if (!i_meas_en) begin
        mode = 0; ev = 1'b0; et = 1'b0;
      end else if (mode == 0) begin
        mode = 1;
      end else if (mode == 1) begin
        if (r) begin rise_at = ecnt; mode = 2; et = 1'b0; end
      end else begin
        if (elapsed >= LIM) begin
          et = 1'b1; ev = 1'b0; mode = 1;
          if (r) rise_at = ecnt;
        end else if (r) begin
          automatic int np = elapsed;
          automatic int nh = fall_at - rise_at;
          ev = (mode == 3) && (np == int'(ep)) && (nh == int'(eh));
          ep = W'(np); eh = W'(nh); el = W'(np - nh);
          mode = 3; rise_at = ecnt;
        end else if (f) begin
          fall_at = ecnt;
        end
      end
      m_pipe = {m_pipe[1:0], i_div_clk};
    end
  end

  always @(negedge clk_ref) begin
    if (!rst) begin
      check("period", o_period, ep);
      check("high", o_high, eh);
      check("low", o_low, el);
      check("odd", o_odd, ep[0]);
      check("valid", o_valid, ev);
      check("timeout", o_timeout, et);
    end
  end

  // Watches the divide-by-256 stretch once the earlier stable result has had time to be replaced.
  int  p256_start = -1;
  bit  v256_seen = 0, t256_seen = 0;
  always @(negedge clk_ref) begin
    if (p256_start >= 0 && tcyc - p256_start > LIM + 8) begin
      if (o_valid) v256_seen = 1;
      if (o_timeout) t256_seen = 1;
    end
  end

  task automatic tick();
    @(posedge clk_ref);
    #2;
  endtask

  task automatic run_div(input int n, input int h, input int periods);
    for (int p = 0; p < periods; p++)
      for (int i = 0; i < n; i++) begin
        i_div_clk = (i < h);
        tick();
      end
  endtask

  task automatic expect_out(input string tag, input int p, input int h, input int v, input int t);
    @(negedge clk_ref);
    check({tag, "_period"}, o_period, p);
    check({tag, "_high"}, o_high, h);
    check({tag, "_low"}, o_low, p - h);
    check({tag, "_odd"}, o_odd, p % 2);
    check({tag, "_valid"}, o_valid, v);
    check({tag, "_timeout"}, o_timeout, t);
    tick();
  endtask

  initial begin
    int waited;
    bit seen;
    #12;
    check("rst_period", o_period, 0);
    check("rst_valid", o_valid, 0);
    check("rst_timeout", o_timeout, 0);
    tick();
    rst = 1'b0;
    tick();
    i_meas_en = 1'b1;

    run_div(4, 2, 6);
    expect_out("div4", 4, 2, 1, 0);
    run_div(5, 3, 5);
    expect_out("div5", 5, 3, 1, 0);
    run_div(6, 3, 5);
    expect_out("div6", 6, 3, 1, 0);

    run_div(4, 2, 5);
    i_div_clk = 1'b0;
    waited = 0; seen = 0;
    while (!seen && waited < 400) begin
      tick();
      waited++;
      if (o_timeout) seen = 1;
    end
    check("stop_seen", seen, 1);
    total++;
    if (waited < 250 || waited > 260) begin
      bad++;
      $display("FAIL stop_latency got=%0d want=250..260", waited);
    end
    expect_out("stopped", 4, 2, 0, 1);
    run_div(4, 2, 5);
    expect_out("resume", 4, 2, 1, 0);

    run_div(2, 1, 6);
    expect_out("div2", 2, 1, 1, 0);
    run_div(255, 100, 3);
    expect_out("div255", 255, 100, 1, 0);
    p256_start = tcyc;
    run_div(256, 128, 4);
    p256_start = -1;
    check("div256_timeout_seen", t256_seen, 1);
    check("div256_valid_seen", v256_seen, 0);

    run_div(4, 2, 6);
    i_div_clk = 1'b1; tick();
    i_meas_en = 1'b0; tick();
    expect_out("endrop", 4, 2, 0, 0);
    run_div(4, 2, 2);
    i_meas_en = 1'b1;
    run_div(4, 2, 6);
    expect_out("reen", 4, 2, 1, 0);

    for (int s = 0; s < 25; s++) begin
      automatic int n = $urandom_range(2, 40);
      automatic int h = $urandom_range(1, n - 1);
      run_div(n, h, $urandom_range(1, 5));
      if ($urandom_range(0, 7) == 0) begin
        i_meas_en = 1'b0;
        run_div(n, h, 1);
        i_meas_en = 1'b1;
      end
    end

    run_div(4, 2, 6);
    i_div_clk = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("arst_period", o_period, 0);
    check("arst_high", o_high, 0);
    check("arst_low", o_low, 0);
    check("arst_valid", o_valid, 0);
    tick();
    rst = 1'b0;
    run_div(4, 2, 6);
    expect_out("post_rst", 4, 2, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
